// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, writeback, issue and sweep-clear handshake.
// The master modport is the core side; the slave modport is regfile_sb.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int TAGW = 4
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   rs1_addr_i;
  logic [AW-1:0]   rs2_addr_i;
  logic [AW-1:0]   dbg_addr_i;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic [XLEN-1:0] dbg_data_o;
  logic [TAGW-1:0] rs1_tag_o;
  logic [TAGW-1:0] rs2_tag_o;
  logic [TAGW-1:0] dbg_tag_o;
  logic            we_i;
  logic [AW-1:0]   rd_addr_i;
  logic [XLEN-1:0] rd_data_i;
  logic [TAGW-1:0] rd_tag_i;
  logic            iss_valid_i;
  logic [AW-1:0]   iss_rd_i;
  logic            rs1_busy_o;
  logic            rs2_busy_o;
  logic            clr_req_i;
  logic            clr_busy_o;

  modport master (
    output rs1_addr_i, rs2_addr_i, dbg_addr_i,
    output we_i, rd_addr_i, rd_data_i, rd_tag_i,
    output iss_valid_i, iss_rd_i, clr_req_i,
    input  rs1_data_o, rs2_data_o, dbg_data_o,
    input  rs1_tag_o, rs2_tag_o, dbg_tag_o,
    input  rs1_busy_o, rs2_busy_o, clr_busy_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i, dbg_addr_i,
    input  we_i, rd_addr_i, rd_data_i, rd_tag_i,
    input  iss_valid_i, iss_rd_i, clr_req_i,
    output rs1_data_o, rs2_data_o, dbg_data_o,
    output rs1_tag_o, rs2_tag_o, dbg_tag_o,
    output rs1_busy_o, rs2_busy_o, clr_busy_o
  );
endinterface

// File: rtl/regfile_sb.sv
// Tagged register file with per-register pending (scoreboard) bits and a
// one-register-per-cycle sweep clear.
//
// state | meaning
// IDLE  | normal operation: reads, writeback, issue, optional bypass
// CLEAR | sweeping idx through the file; writes/issues/requests ignored
module regfile_sb #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int TAGW    = 4,
  parameter int BYPASS  = 1,
  parameter int ZERO_X0 = 1
) (
  input logic         clk_i,
  input logic         reset_i,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] FIRST_IDX = (ZERO_X0 != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   idx, idx_nx;
  logic [XLEN-1:0] data_q [NREG];
  logic [TAGW-1:0] tag_q  [NREG];
  logic [NREG-1:0] pend_q;

  logic wr_ok, iss_ok, src1_ok, src2_ok, dbg_ok, hit1, hit2;

  // Address is backed by storage and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NREG) && !((ZERO_X0 != 0) && (a == '0));
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    idx_nx         = idx;
    bus.clr_busy_o = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr_req_i) begin
          state_nx = CLEAR;
          idx_nx   = FIRST_IDX;
        end
      end
      CLEAR: begin
        bus.clr_busy_o = 1'b1;
        if (idx == LAST_IDX) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  always_comb begin
    wr_ok   = (state == IDLE) && bus.we_i && addr_ok(bus.rd_addr_i);
    iss_ok  = (state == IDLE) && bus.iss_valid_i && addr_ok(bus.iss_rd_i);
    src1_ok = addr_ok(bus.rs1_addr_i);
    src2_ok = addr_ok(bus.rs2_addr_i);
    dbg_ok  = addr_ok(bus.dbg_addr_i);
    hit1    = (BYPASS != 0) && wr_ok && (bus.rd_addr_i == bus.rs1_addr_i);
    hit2    = (BYPASS != 0) && wr_ok && (bus.rd_addr_i == bus.rs2_addr_i);
  end

  // Sweep has priority; issue is applied after writeback so issue wins.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      pend_q <= '0;
    end else if (state == CLEAR) begin
      data_q[idx] <= '0;
      tag_q[idx]  <= '0;
      pend_q[idx] <= 1'b0;
    end else begin
      if (wr_ok) begin
        data_q[bus.rd_addr_i] <= bus.rd_data_i;
        tag_q[bus.rd_addr_i]  <= bus.rd_tag_i;
        pend_q[bus.rd_addr_i] <= 1'b0;
      end
      if (iss_ok) pend_q[bus.iss_rd_i] <= 1'b1;
    end
  end

  always_comb begin
    bus.rs1_data_o = '0;
    bus.rs1_tag_o  = '0;
    bus.rs1_busy_o = 1'b0;
    bus.rs2_data_o = '0;
    bus.rs2_tag_o  = '0;
    bus.rs2_busy_o = 1'b0;
    bus.dbg_data_o = '0;
    bus.dbg_tag_o  = '0;
    if (src1_ok) begin
      bus.rs1_data_o = hit1 ? bus.rd_data_i : data_q[bus.rs1_addr_i];
      bus.rs1_tag_o  = hit1 ? bus.rd_tag_i  : tag_q[bus.rs1_addr_i];
      bus.rs1_busy_o = pend_q[bus.rs1_addr_i] && !hit1;
    end
    if (src2_ok) begin
      bus.rs2_data_o = hit2 ? bus.rd_data_i : data_q[bus.rs2_addr_i];
      bus.rs2_tag_o  = hit2 ? bus.rd_tag_i  : tag_q[bus.rs2_addr_i];
      bus.rs2_busy_o = pend_q[bus.rs2_addr_i] && !hit2;
    end
    if (dbg_ok) begin
      bus.dbg_data_o = data_q[bus.dbg_addr_i];
      bus.dbg_tag_o  = tag_q[bus.dbg_addr_i];
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypassing instance (A) and a non-bypassing one (B)
// share stimulus; vector table plus sweep and reset-abort sequences.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic reset_i;

  logic        we, iss_valid, clr_req;
  logic [4:0]  rd_addr, iss_rd, rs1_addr, rs2_addr, dbg_addr;
  logic [31:0] rd_data;
  logic [3:0]  rd_tag;

  int errors = 0;
  int checks = 0;

  regfile_sb_if #(.XLEN(32), .NREG(32), .TAGW(4)) ifa ();
  regfile_sb_if #(.XLEN(32), .NREG(32), .TAGW(4)) ifb ();

  assign ifa.we_i = we;             assign ifb.we_i = we;
  assign ifa.rd_addr_i = rd_addr;   assign ifb.rd_addr_i = rd_addr;
  assign ifa.rd_data_i = rd_data;   assign ifb.rd_data_i = rd_data;
  assign ifa.rd_tag_i = rd_tag;     assign ifb.rd_tag_i = rd_tag;
  assign ifa.iss_valid_i = iss_valid; assign ifb.iss_valid_i = iss_valid;
  assign ifa.iss_rd_i = iss_rd;     assign ifb.iss_rd_i = iss_rd;
  assign ifa.clr_req_i = clr_req;   assign ifb.clr_req_i = clr_req;
  assign ifa.rs1_addr_i = rs1_addr; assign ifb.rs1_addr_i = rs1_addr;
  assign ifa.rs2_addr_i = rs2_addr; assign ifb.rs2_addr_i = rs2_addr;
  assign ifa.dbg_addr_i = dbg_addr; assign ifb.dbg_addr_i = dbg_addr;

  regfile_sb #(.XLEN(32), .NREG(32), .TAGW(4), .BYPASS(1), .ZERO_X0(1))
    dut_a (.clk_i(clk), .reset_i(reset_i), .bus(ifa));
  regfile_sb #(.XLEN(32), .NREG(32), .TAGW(4), .BYPASS(0), .ZERO_X0(1))
    dut_b (.clk_i(clk), .reset_i(reset_i), .bus(ifb));

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [3:0]  wt;
    logic        iss;
    logic [4:0]  ird;
    logic [4:0]  a1, a2, ad;
    logic [31:0] e1d;
    logic [3:0]  e1t;
    logic        e1b;
    logic [31:0] e2d, e2nd, edbg;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] e1d;
    logic [3:0]  e1t;
    logic        e1b;
    logic [31:0] e2d, e2nd, edbg;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fill(input int i);
    return 32'h1000_0000 | 32'(i);
  endfunction

  task automatic idle_inputs();
    we = 1'b0; iss_valid = 1'b0; clr_req = 1'b0;
    rd_addr = '0; rd_data = '0; rd_tag = '0; iss_rd = '0;
  endtask

  initial begin
    exp_t e;
    int   n;
    int   k;

    vecs[0]  = '{1, 5, 32'hDEADBEEF, 4'h3, 0, 0, 5, 0, 5, 32'hDEADBEEF, 4'h3, 0, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{0, 0, 32'h0, 4'h0, 0, 0, 5, 5, 5, 32'hDEADBEEF, 4'h3, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1, 7, 32'h12345678, 4'h1, 0, 0, 0, 7, 7, 32'h0, 4'h0, 0, 32'h12345678, 32'h0, 32'h0};
    vecs[3]  = '{0, 0, 32'h0, 4'h0, 0, 0, 7, 7, 7, 32'h12345678, 4'h1, 0, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[4]  = '{1, 0, 32'hFFFFFFFF, 4'hF, 1, 0, 0, 0, 0, 32'h0, 4'h0, 0, 32'h0, 32'h0, 32'h0};
    vecs[5]  = '{0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 32'h0, 32'h0, 32'h0};
    vecs[6]  = '{0, 0, 32'h0, 4'h0, 1, 9, 9, 9, 9, 32'h0, 4'h0, 0, 32'h0, 32'h0, 32'h0};
    vecs[7]  = '{0, 0, 32'h0, 4'h0, 0, 0, 9, 9, 9, 32'h0, 4'h0, 1, 32'h0, 32'h0, 32'h0};
    vecs[8]  = '{1, 9, 32'hAAAA0009, 4'h9, 1, 9, 9, 9, 9, 32'hAAAA0009, 4'h9, 0, 32'hAAAA0009, 32'h0, 32'h0};
    vecs[9]  = '{0, 0, 32'h0, 4'h0, 0, 0, 9, 9, 9, 32'hAAAA0009, 4'h9, 1, 32'hAAAA0009, 32'hAAAA0009, 32'hAAAA0009};
    vecs[10] = '{1, 9, 32'h00000055, 4'h2, 0, 0, 9, 5, 9, 32'h00000055, 4'h2, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hAAAA0009};
    vecs[11] = '{0, 0, 32'h0, 4'h0, 0, 0, 9, 7, 5, 32'h00000055, 4'h2, 0, 32'h12345678, 32'h12345678, 32'hDEADBEEF};

    reset_i = 1'b1;
    idle_inputs();
    rs1_addr = 5'd5; rs2_addr = 5'd0; dbg_addr = 5'd5;
    #12;
    chk("reset rs1_data", ifa.rs1_data_o, 32'h0);
    chk("reset clr_busy", 32'(ifa.clr_busy_o), 32'h0);
    @(negedge clk);
    reset_i = 1'b0;

    // Table vectors through the scoreboard queue
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      we = vecs[i].we; rd_addr = vecs[i].rd; rd_data = vecs[i].wd; rd_tag = vecs[i].wt;
      iss_valid = vecs[i].iss; iss_rd = vecs[i].ird;
      rs1_addr = vecs[i].a1; rs2_addr = vecs[i].a2; dbg_addr = vecs[i].ad;
      sb.push_back('{i, vecs[i].e1d, vecs[i].e1t, vecs[i].e1b, vecs[i].e2d, vecs[i].e2nd, vecs[i].edbg});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d rs1_data", e.id), ifa.rs1_data_o, e.e1d);
      chk($sformatf("v%0d rs1_tag", e.id), 32'(ifa.rs1_tag_o), 32'(e.e1t));
      chk($sformatf("v%0d rs1_busy", e.id), 32'(ifa.rs1_busy_o), 32'(e.e1b));
      chk($sformatf("v%0d rs2_data A", e.id), ifa.rs2_data_o, e.e2d);
      chk($sformatf("v%0d rs2_data B", e.id), ifb.rs2_data_o, e.e2nd);
      chk($sformatf("v%0d dbg_data", e.id), ifa.dbg_data_o, e.edbg);
    end

    // Fill x1..x31, leave x3 pending, then sweep
    for (int i = 1; i < 32; i++) begin
      @(posedge clk); #1;
      we = 1'b1; rd_addr = 5'(i); rd_data = fill(i); rd_tag = 4'(i);
      iss_valid = (i == 31); iss_rd = 5'd3;
    end
    @(posedge clk); #1;
    idle_inputs();
    clr_req = 1'b1;
    rs1_addr = 5'd31;
    n = 0;
    @(posedge clk); #1;
    clr_req = 1'b0;
    @(negedge clk);
    chk("sweep no-bypass x31", ifa.rs1_data_o, fill(31));
    if (ifa.clr_busy_o) n++;
    @(posedge clk); #1;
    we = 1'b1; rd_addr = 5'd1; rd_data = 32'h0000_0BAD; rd_tag = 4'hB;
    iss_valid = 1'b1; iss_rd = 5'd1; clr_req = 1'b1;
    @(negedge clk);
    if (ifa.clr_busy_o) n++;
    @(posedge clk); #1;
    idle_inputs();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ifa.clr_busy_o) n++;
      else break;
    end
    chk("sweep busy cycles", 32'(n), 32'd31);
    chk("sweep clr_busy after", 32'(ifa.clr_busy_o), 32'h0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i);
      #1;
      chk($sformatf("post-sweep x%0d A", i), ifa.rs1_data_o, 32'h0);
      chk($sformatf("post-sweep x%0d B", i), ifb.rs2_data_o, 32'h0);
    end
    rs1_addr = 5'd1; rs2_addr = 5'd3; #1;
    chk("post-sweep x1 tag", 32'(ifa.rs1_tag_o), 32'h0);
    chk("post-sweep x1 busy", 32'(ifa.rs1_busy_o), 32'h0);
    chk("post-sweep x3 busy", 32'(ifa.rs2_busy_o), 32'h0);

    // Reset in the middle of a sweep
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      we = 1'b1; rd_addr = 5'(i); rd_data = fill(i); rd_tag = 4'(i);
    end
    @(posedge clk); #1;
    idle_inputs();
    clr_req = 1'b1;
    rs1_addr = 5'd12; rs2_addr = 5'd10;
    @(posedge clk); #1;
    clr_req = 1'b0;
    k = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ifa.clr_busy_o) k++;
      if (k == 10) break;
    end
    chk("abort reached idx 10", 32'(k), 32'd10);
    chk("abort x12 before reset", ifa.rs1_data_o, fill(12));
    chk("abort x10 before reset", ifa.rs2_data_o, fill(10));
    reset_i = 1'b1;
    #1;
    chk("abort clr_busy A", 32'(ifa.clr_busy_o), 32'h0);
    chk("abort clr_busy B", 32'(ifb.clr_busy_o), 32'h0);
    chk("abort x12 zero", ifa.rs1_data_o, 32'h0);
    chk("abort x10 zero", ifa.rs2_data_o, 32'h0);
    #1;
    reset_i = 1'b0;
    we = 1'b1; rd_addr = 5'd12; rd_data = 32'hCAFEF00D; rd_tag = 4'h6;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    chk("post-reset write x12", ifa.rs1_data_o, 32'hCAFEF00D);
    chk("post-reset write x12 B", ifb.rs1_data_o, 32'hCAFEF00D);
    chk("post-reset clr_busy", 32'(ifa.clr_busy_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width per register.
REQ-002 SHALL have parameter NREG, default 32, register count (2..64); AW = clog2(NREG).
REQ-003 SHALL have parameter TAGW, default 4, width of the per-register metadata tag.
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-005 SHALL have parameter ZERO_X0, default 1, 1 = register 0 hardwired to zero.
REQ-006 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_i  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ports rs1_addr_i, rs2_addr_i, dbg_addr_i  in  AW  read and debug addresses.
REQ-009 SHALL have ports rs1_data_o, rs2_data_o, dbg_data_o  out  XLEN  read data.
REQ-010 SHALL have ports rs1_tag_o, rs2_tag_o, dbg_tag_o  out  TAGW  read tags.
REQ-011 SHALL have ports we_i  in  1, rd_addr_i  in  AW, rd_data_i  in  XLEN, rd_tag_i  in  TAGW  writeback.
REQ-012 SHALL have ports iss_valid_i  in  1, iss_rd_i  in  AW  issue, marks the destination as pending.
REQ-013 SHALL have ports rs1_busy_o, rs2_busy_o  out  1  source operand pending.
REQ-014 SHALL have ports clr_req_i  in  1  sweep-clear request; clr_busy_o  out  1  sweep in progress.

Function
REQ-015 SHALL drive all read outputs combinationally from the addressed register and tag.
REQ-016 SHALL, with ZERO_X0=1, return data 0, tag 0 and busy 0 for address 0, and ignore writes and issues to address 0.
REQ-017 SHALL return 0 and ignore writes and issues for addresses >= NREG.
REQ-018 SHALL, in state IDLE with we_i=1, write rd_data_i and rd_tag_i to rd_addr_i at the rising edge.
REQ-019 SHALL, with BYPASS=1 and we_i=1 in IDLE and rd_addr_i == rsN_addr_i (valid, non-zero), drive rsN_data_o and rsN_tag_o from rd_data_i and rd_tag_i in that cycle; dbg port is never bypassed.
REQ-020 SHALL keep one pending bit per register: set at the edge by iss_valid_i on iss_rd_i, cleared at the edge by we_i on rd_addr_i.
REQ-021 SHALL, when set and clear target the same register in one cycle, leave the pending bit set (issue wins).
REQ-022 SHALL drive rsN_busy_o = pend[rsN_addr_i], masked to 0 when BYPASS=1 and a same-cycle writeback matches rsN_addr_i.
REQ-023 SHALL implement FSM states IDLE and CLEAR; IDLE -> CLEAR on clr_req_i=1; clr_busy_o=1 exactly while in CLEAR.
REQ-024 SHALL, in CLEAR, zero data, tag and pending bit of one register per cycle using an index counter running 1..NREG-1 (0..NREG-1 when ZERO_X0=0), then return to IDLE at the edge that clears the last index; total NREG-1 (or NREG) cycles.
REQ-025 SHALL ignore we_i, iss_valid_i and clr_req_i while in CLEAR; reads during CLEAR return current array contents with no bypass.
REQ-026 SHALL, on clr_req_i coinciding with we_i or iss_valid_i in IDLE, perform the write/issue at that edge and then begin the sweep.

Reset
REQ-027 SHALL, while reset_i=1, asynchronously clear all registers, tags and pending bits, force IDLE, index counter 0, clr_busy_o 0.
REQ-028 SHALL, on reset asserted mid-sweep, abort the sweep and return to IDLE with everything zeroed; all read outputs then 0.

Verification
REQ-029 SHALL verify: write x5=0xDEADBEEF tag 0x3, next cycle read rs1=5 -> rs1_data_o=0xDEADBEEF, rs1_tag_o=0x3.
REQ-030 SHALL verify: we_i=1 rd=7 data=0x12345678 with rs2=7 same cycle -> rs2_data_o=0x12345678 (BYPASS=1), old value (BYPASS=0).
REQ-031 SHALL verify: write x0=0xFFFFFFFF, iss_rd_i=0 -> rs1=0 reads 0, rs1_busy_o=0.
REQ-032 SHALL verify: issue rd=9, then rs1=9 -> busy=1; writeback 9 with simultaneous re-issue 9 -> busy stays 1 next cycle.
REQ-033 SHALL verify: fill x1..x31 with nonzero, pulse clr_req_i -> clr_busy_o=1 for 31 cycles, writes ignored, all reads 0 afterwards.
REQ-034 SHALL verify: reset_i pulse at sweep index 10 -> clr_busy_o=0 immediately, all registers 0, new write accepted next edge.
